regfile_port_arb: RTL

REGFILE_PORT_ARB -- requirements
Module: regfile_port_arb

---
 rtl/regfile_port_arb.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/regfile_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_port_arb
// Description : Two-master arbiter in front of a 2-read / 1-write register
//               file. One read grant per cycle (round-robin on ties), one
//               write grant per cycle (m0 priority with an m1 starvation
//               guard). Read data arrives one cycle after the grant and is
//               steered to the granted master's response lane.
//               Optional macro RF_ARB_BYPASS_EN forwards same-cycle write
//               data into a colliding read's response.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_port_arb #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,

    // master 0
    input  logic        m0_rd_valid,
    output logic        m0_rd_ready,
    input  logic [4:0]  m0_ra1,
    input  logic [4:0]  m0_ra2,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rd1,
    output logic [31:0] m0_rd2,
    input  logic        m0_wr_valid,
    output logic        m0_wr_ready,
    input  logic [4:0]  m0_wa,
    input  logic [31:0] m0_wd,

    // master 1
    input  logic        m1_rd_valid,
    output logic        m1_rd_ready,
    input  logic [4:0]  m1_ra1,
    input  logic [4:0]  m1_ra2,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rd1,
    output logic [31:0] m1_rd2,
    input  logic        m1_wr_valid,
    output logic        m1_wr_ready,
    input  logic [4:0]  m1_wa,
    input  logic [31:0] m1_wd,

    // register file side
    output logic [4:0]  rf_A1,
    output logic [4:0]  rf_A2,
    output logic [4:0]  rf_A3,
    output logic [31:0] rf_WD3,
    output logic        rf_WE,
    input  logic [31:0] rf_RD1,
    input  logic [31:0] rf_RD2
);

    localparam logic [1:0] c_STARVE_MAX = 2'd3;

    // ------------------------------------------------------------------
    // Read arbitration
    // ------------------------------------------------------------------
    logic        r_rr_last_m1;   // 1: m1 was the most recent read winner
    logic        w_rd_gnt0;
    logic        w_rd_gnt1;
    logic        w_rd_any;
    logic        r_rsp_valid0;
    logic        r_rsp_valid1;

    // Pick the read winner; the master not granted last wins a tie.
    always_comb begin
        w_rd_gnt0 = 1'b0;
        w_rd_gnt1 = 1'b0;
        if (rst_n) begin
            if (m0_rd_valid && m1_rd_valid) begin
                if (r_rr_last_m1) begin
                    w_rd_gnt0 = 1'b1;
                end else begin
                    w_rd_gnt1 = 1'b1;
                end
            end else begin
                w_rd_gnt0 = m0_rd_valid;
                w_rd_gnt1 = m1_rd_valid;
            end
        end
    end

    assign w_rd_any    = w_rd_gnt0 | w_rd_gnt1;
    assign m0_rd_ready = w_rd_gnt0;
    assign m1_rd_ready = w_rd_gnt1;

    // Steer the winner's read addresses; idle reads present address 0.
    always_comb begin
        rf_A1 = 5'd0;
        rf_A2 = 5'd0;
        if (w_rd_gnt0) begin
            rf_A1 = m0_ra1;
            rf_A2 = m0_ra2;
        end else if (w_rd_gnt1) begin
            rf_A1 = m1_ra1;
            rf_A2 = m1_ra2;
        end
    end

    // Round-robin pointer remembers who won the last granted read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_last_m1 <= RR_INIT;
        end else if (w_rd_gnt0) begin
            r_rr_last_m1 <= 1'b0;
        end else if (w_rd_gnt1) begin
            r_rr_last_m1 <= 1'b1;
        end
    end

    // Response valid follows the grant by exactly one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
        end else begin
            r_rsp_valid0 <= w_rd_gnt0;
            r_rsp_valid1 <= w_rd_gnt1;
        end
    end

    // Gating with rst_n kills a response whose grant preceded an asserted
    // reset, so nothing leaks out while reset is held.
    assign m0_rsp_valid = r_rsp_valid0 & rst_n;
    assign m1_rsp_valid = r_rsp_valid1 & rst_n;

    // ------------------------------------------------------------------
    // Write arbitration
    // ------------------------------------------------------------------
    logic [1:0]  r_starve;       // cycles m1 has waited on a write
    logic        w_wr_gnt0;
    logic        w_wr_gnt1;
    logic        w_wr_any;

    // m0 wins writes unless m1 has been waiting for three cycles.
    always_comb begin
        w_wr_gnt0 = 1'b0;
        w_wr_gnt1 = 1'b0;
        if (rst_n) begin
            if (m1_wr_valid && (!m0_wr_valid || (r_starve == c_STARVE_MAX))) begin
                w_wr_gnt1 = 1'b1;
            end else if (m0_wr_valid) begin
                w_wr_gnt0 = 1'b1;
            end
        end
    end

    assign w_wr_any    = w_wr_gnt0 | w_wr_gnt1;
    assign m0_wr_ready = w_wr_gnt0;
    assign m1_wr_ready = w_wr_gnt1;

    // Steer the write winner's address and data to the register file.
    always_comb begin
        rf_A3  = 5'd0;
        rf_WD3 = 32'd0;
        if (w_wr_gnt1) begin
            rf_A3  = m1_wa;
            rf_WD3 = m1_wd;
        end else if (w_wr_gnt0) begin
            rf_A3  = m0_wa;
            rf_WD3 = m0_wd;
        end
    end

    // Writes to register 0 are acknowledged but never reach the array.
    assign rf_WE = w_wr_any && (rf_A3 != 5'd0);

    // Starvation counter; the grant at the max value clears it, so it never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve <= 2'd0;
        end else if (!m1_wr_valid || w_wr_gnt1) begin
            r_starve <= 2'd0;
        end else begin
            r_starve <= r_starve + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Response data path
    // ------------------------------------------------------------------
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;

`ifdef RF_ARB_BYPASS_EN
    logic        r_byp1;
    logic        r_byp2;
    logic [31:0] r_byp_data;

    // Capture a same-cycle read/write address collision and the write data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_byp1     <= 1'b0;
            r_byp2     <= 1'b0;
            r_byp_data <= 32'd0;
        end else begin
            r_byp1     <= w_rd_any && rf_WE && (rf_A1 == rf_A3);
            r_byp2     <= w_rd_any && rf_WE && (rf_A2 == rf_A3);
            r_byp_data <= rf_WD3;
        end
    end

    assign w_rd1 = r_byp1 ? r_byp_data : rf_RD1;
    assign w_rd2 = r_byp2 ? r_byp_data : rf_RD2;
`else
    // Without forwarding a colliding read returns the pre-write value.
    assign w_rd1 = rf_RD1;
    assign w_rd2 = rf_RD2;
`endif

    // Both lanes carry the same data; rsp_valid says whose it is.
    assign m0_rd1 = w_rd1;
    assign m0_rd2 = w_rd2;
    assign m1_rd1 = w_rd1;
    assign m1_rd2 = w_rd2;

endmodule
`default_nettype wire
